// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared widths, frame geometry and bank states for the MFCC front end
package mfcc_pkg;
    localparam int Q        = 15;
    localparam int IN_W     = 16;
    localparam int OUT_W    = 32;
    localparam int N_FFT    = 512;
    localparam int NUM_BINS = 257;
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};

    typedef enum logic [1:0] {EMPTY, FILLING, READY, STREAMING} bank_state_t;
endpackage

// File: rtl/periodogram_power_calc.sv
// power_calc: registered squared magnitude of a Q15 complex bin, saturated to Q30
module power_calc #(
    parameter int IN_W  = mfcc_pkg::IN_W,
    parameter int OUT_W = mfcc_pkg::OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  re,
    input  logic signed [IN_W-1:0]  im,
    output logic        [OUT_W-1:0] p
);
    localparam int SW = 2 * IN_W + 1;
    localparam int WW = (SW > OUT_W ? SW : OUT_W) + 1;

    logic signed [SW-1:0] sum;
    logic        [WW-1:0] sum_w;
    logic                 sat;

    // full-precision sum of squares; it is never negative, so zero-extension is exact
    always_comb begin
        sum   = SW'(re) * SW'(re) + SW'(im) * SW'(im);
        sum_w = WW'(unsigned'(sum));
        sat   = sum_w >= (WW'(1) << (OUT_W - 1));
    end

    // clamp anything that does not fit the signed output range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p <= '0;
        else        p <= sat ? {1'b0, {(OUT_W-1){1'b1}}} : OUT_W'(sum);
    end
endmodule

// File: rtl/periodogram_streamer.sv
// periodogram_streamer: FFT bins to Q30 power, ping-pong buffered, paced out to the mel filterbank
module periodogram_streamer
    import mfcc_pkg::*;
#(
    parameter int N_FFT    = mfcc_pkg::N_FFT,
    parameter int NUM_BINS = mfcc_pkg::NUM_BINS,
    parameter int IN_W     = mfcc_pkg::IN_W,
    parameter int OUT_W    = mfcc_pkg::OUT_W,
    parameter int STRIDE   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  fft_re,
    input  logic signed [IN_W-1:0]  fft_im,
    input  logic                    fft_valid,
    output logic signed [OUT_W-1:0] data_out,
    output logic                    data_valid,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    overrun
);
    localparam int BW = N_FFT > 1 ? $clog2(N_FFT) : 1;
    localparam int AW = NUM_BINS > 1 ? $clog2(NUM_BINS) : 1;
    localparam int CW = STRIDE > 1 ? $clog2(STRIDE) : 1;
    localparam logic [BW-1:0] LAST_IN  = BW'(N_FFT - 1);
    localparam logic [AW-1:0] LAST_BIN = AW'(NUM_BINS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(STRIDE - 1);

    typedef enum logic {S_IDLE, S_RUN} stream_t;

    logic [BW-1:0]    bin_cnt;
    logic             wr_bank;
    logic             dropping;
    logic             drop_now;
    logic             store;
    logic             s1_en;
    logic             s1_bank;
    logic [AW-1:0]    s1_addr;
    logic [OUT_W-1:0] p;
    logic [OUT_W-1:0] mem [2][NUM_BINS];
    bank_state_t      bank_st [2];
    bank_state_t      bank_nx [2];
    stream_t          st;
    stream_t          st_nx;
    logic             st_bank;
    logic [AW-1:0]    st_idx;
    logic [CW-1:0]    st_cnt;
    logic             start;
    logic             start_bank;
    logic             pulse;
    logic             last_pulse;

    power_calc #(.IN_W(IN_W), .OUT_W(OUT_W)) u_power (
        .clk  (clk),
        .rst_n(rst_n),
        .re   (fft_re),
        .im   (fft_im),
        .p    (p)
    );

    // a frame is kept only if its bank is free when bin 0 shows up
    always_comb begin
        drop_now = (bin_cnt == '0) ? (bank_st[wr_bank] != EMPTY) : dropping;
        store    = fft_valid && !drop_now && (int'(bin_cnt) < NUM_BINS);
    end

    // input side: bin counter, write-bank selection, drop tracking, stage-1 address pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt  <= '0;
            wr_bank  <= 1'b0;
            dropping <= 1'b0;
            overrun  <= 1'b0;
            s1_en    <= 1'b0;
            s1_bank  <= 1'b0;
            s1_addr  <= '0;
        end else begin
            s1_en   <= store;
            s1_bank <= wr_bank;
            s1_addr <= AW'(bin_cnt);
            if (fft_valid) begin
                bin_cnt  <= (bin_cnt == LAST_IN) ? '0 : bin_cnt + BW'(1);
                dropping <= drop_now;
                if (bin_cnt == '0 && drop_now) overrun <= 1'b1;
                if (bin_cnt == LAST_IN && !drop_now) wr_bank <= ~wr_bank;
            end
        end
    end

    // stage 2: the registered power lands in its bank at the bin address
    always_ff @(posedge clk) begin
        if (s1_en) mem[s1_bank][s1_addr] <= p;
    end

    // streamer next state: claim a READY bank when idle, pulse every STRIDE cycles while running
    always_comb begin
        st_nx      = st;
        start      = 1'b0;
        start_bank = 1'b0;
        pulse      = 1'b0;
        last_pulse = 1'b0;
        if (st == S_IDLE) begin
            if (bank_st[0] == READY || bank_st[1] == READY) begin
                start      = 1'b1;
                start_bank = bank_st[0] != READY;
                st_nx      = S_RUN;
            end
        end else begin
            pulse      = st_cnt == '0;
            last_pulse = pulse && st_idx == LAST_BIN;
            if (last_pulse) st_nx = S_IDLE;
        end
    end

    // bank lifecycle; each source only touches banks in its own state, so no two collide
    always_comb begin
        bank_nx = bank_st;
        if (fft_valid && bin_cnt == '0 && !drop_now) bank_nx[wr_bank] = FILLING;
        if (s1_en && s1_addr == LAST_BIN) bank_nx[s1_bank] = READY;
        if (start) bank_nx[start_bank] = STREAMING;
        if (last_pulse) bank_nx[st_bank] = EMPTY;
    end

    // bank and streamer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st <= '{EMPTY, EMPTY};
            st      <= S_IDLE;
        end else begin
            bank_st <= bank_nx;
            st      <= st_nx;
        end
    end

    // streamer datapath: pacing counter, registered buffer read, output qualifiers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_bank    <= 1'b0;
            st_idx     <= '0;
            st_cnt     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= pulse;
            frame_done <= last_pulse;
            busy       <= (bank_st[0] inside {READY, STREAMING}) || (bank_st[1] inside {READY, STREAMING});
            if (start) begin
                st_bank <= start_bank;
                st_idx  <= '0;
                st_cnt  <= '0;
            end else if (st == S_RUN) begin
                st_cnt <= (st_cnt == LAST_CNT) ? '0 : st_cnt + CW'(1);
                if (pulse) begin
                    data_out <= mem[st_bank][st_idx];
                    st_idx   <= st_idx + AW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_periodogram_streamer.sv
// tb_periodogram_streamer: randomized scenarios against a plain-arithmetic power/stream model
module tb_periodogram_streamer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [15:0] fft_re = '0;
    logic signed [15:0] fft_im = '0;
    logic fft_valid = 1'b0;

    logic signed [31:0] do_a, do_b, do_c, do_d;
    logic dv_a, dv_b, dv_c, dv_d;
    logic fd_a, fd_b, fd_c, fd_d;
    logic bz_a, bz_b, bz_c, bz_d;
    logic ov_a, ov_b, ov_c, ov_d;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] qa[$], qb[$], qc[$], qd[$];
    int ca[$], cc[$];
    bit fa[$];
    int nfd_a = 0;
    int fall_c = -1;
    int last_fd_c = -1;
    logic busy_c_q = 1'b0;

    logic signed [15:0] fr_re [512];
    logic signed [15:0] fr_im [512];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    periodogram_streamer #(.N_FFT(16), .NUM_BINS(9), .IN_W(16), .OUT_W(32), .STRIDE(2)) u_a (
        .clk(clk), .rst_n(rst_n), .fft_re(fft_re), .fft_im(fft_im), .fft_valid(fft_valid),
        .data_out(do_a), .data_valid(dv_a), .frame_done(fd_a), .busy(bz_a), .overrun(ov_a));
    periodogram_streamer #(.N_FFT(16), .NUM_BINS(9), .IN_W(16), .OUT_W(32), .STRIDE(4)) u_b (
        .clk(clk), .rst_n(rst_n), .fft_re(fft_re), .fft_im(fft_im), .fft_valid(fft_valid),
        .data_out(do_b), .data_valid(dv_b), .frame_done(fd_b), .busy(bz_b), .overrun(ov_b));
    periodogram_streamer #(.N_FFT(16), .NUM_BINS(9), .IN_W(16), .OUT_W(32), .STRIDE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .fft_re(fft_re), .fft_im(fft_im), .fft_valid(fft_valid),
        .data_out(do_c), .data_valid(dv_c), .frame_done(fd_c), .busy(bz_c), .overrun(ov_c));
    periodogram_streamer u_d (
        .clk(clk), .rst_n(rst_n), .fft_re(fft_re), .fft_im(fft_im), .fft_valid(fft_valid),
        .data_out(do_d), .data_valid(dv_d), .frame_done(fd_d), .busy(bz_d), .overrun(ov_d));

    // capture every streamed sample away from the active edge
    always @(negedge clk) begin
        if (dv_a) begin qa.push_back(do_a); ca.push_back(cyc); fa.push_back(fd_a); end
        if (fd_a) nfd_a++;
        if (dv_b) qb.push_back(do_b);
        if (dv_c) begin qc.push_back(do_c); cc.push_back(cyc); end
        if (dv_d) qd.push_back(do_d);
        if (fd_c) last_fd_c = cyc;
        if (busy_c_q && !bz_c) fall_c = cyc;
        busy_c_q = bz_c;
    end

    function automatic logic [31:0] pw(input logic signed [15:0] re, input logic signed [15:0] im);
        longint s;
        s = longint'(re) * longint'(re) + longint'(im) * longint'(im);
        return (s >= 64'sd2147483648) ? 32'h7FFF_FFFF : 32'(s);
    endfunction

    function automatic int qsize(input int w);
        case (w)
            0: return qa.size();
            1: return qb.size();
            2: return qc.size();
            default: return qd.size();
        endcase
    endfunction

    task automatic wait_q(input int w, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (qsize(w) >= target) break;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        fft_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic signed [15:0] re, input logic signed [15:0] im);
        fft_re = re;
        fft_im = im;
        fft_valid = 1'b1;
        @(negedge clk);
        fft_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input int gmax);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(gmax, 0)) @(negedge clk);
            send(fr_re[k], fr_im[k]);
        end
    endtask

    task automatic randomize_frame(input int n);
        for (int k = 0; k < n; k++) begin
            fr_re[k] = 16'($urandom);
            fr_im[k] = 16'($urandom);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (do_a !== 32'sd0) begin failures++; $display("FAIL reset_data_out got=%0h exp=0", do_a); end
        checks++; if (dv_a !== 1'b0) begin failures++; $display("FAIL reset_data_valid got=%b exp=0", dv_a); end
        checks++; if (fd_a !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", fd_a); end
        checks++; if ({bz_a, bz_b, bz_c, bz_d} !== 4'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0000", {bz_a, bz_b, bz_c, bz_d}); end
        checks++; if ({ov_a, ov_b, ov_c, ov_d} !== 4'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0000", {ov_a, ov_b, ov_c, ov_d}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        int base, acc8, nfd0;
        apply_reset();
        base = qa.size();
        nfd0 = nfd_a;
        acc8 = -1;
        for (int k = 0; k < 16; k++) begin
            send(16'(k), 16'sd0);
            if (k == 8) acc8 = cyc;
        end
        wait_q(0, base + 9, 100);
        repeat (10) @(negedge clk);
        checks++; if (qa.size() - base !== 9) begin failures++; $display("FAIL ramp_count got=%0d exp=9", qa.size() - base); end
        if (qa.size() - base >= 9) begin
            checks++; if (ca[base] !== acc8 + 3) begin failures++; $display("FAIL ramp_latency got=%0d exp=%0d", ca[base] - acc8, 3); end
            for (int i = 0; i < 9; i++) begin
                checks++; if (qa[base+i] !== 32'(i * i)) begin failures++; $display("FAIL ramp_val[%0d] got=%0d exp=%0d", i, qa[base+i], i * i); end
                checks++; if (fa[base+i] !== (i == 8)) begin failures++; $display("FAIL ramp_frame_done[%0d] got=%b exp=%b", i, fa[base+i], i == 8); end
                if (i > 0) begin
                    checks++; if (ca[base+i] - ca[base+i-1] !== 2) begin failures++; $display("FAIL ramp_spacing[%0d] got=%0d exp=2", i, ca[base+i] - ca[base+i-1]); end
                end
            end
        end
        checks++; if (nfd_a - nfd0 !== 1) begin failures++; $display("FAIL ramp_frame_done_count got=%0d exp=1", nfd_a - nfd0); end
        checks++; if (bz_a !== 1'b0) begin failures++; $display("FAIL ramp_busy_idle got=%b exp=0", bz_a); end
        checks++; if (ov_a !== 1'b0) begin failures++; $display("FAIL ramp_overrun got=%b exp=0", ov_a); end
    endtask

    task automatic test_values();
        int base;
        apply_reset();
        base = qa.size();
        randomize_frame(16);
        fr_re[3] = 16'sd181;    fr_im[3] = 16'sd181;
        fr_re[5] = -16'sd32768; fr_im[5] = -16'sd32768;
        fr_re[6] = -16'sd32768; fr_im[6] = 16'sd0;
        send_frame(16, 0);
        wait_q(0, base + 9, 100);
        repeat (10) @(negedge clk);
        checks++; if (qa.size() - base !== 9) begin failures++; $display("FAIL values_count got=%0d exp=9", qa.size() - base); end
        if (qa.size() - base >= 9) begin
            for (int i = 0; i < 9; i++) begin
                checks++; if (qa[base+i] !== pw(fr_re[i], fr_im[i])) begin failures++; $display("FAIL values_val[%0d] got=%0h exp=%0h", i, qa[base+i], pw(fr_re[i], fr_im[i])); end
            end
            checks++; if (qa[base+3] !== 32'd65522) begin failures++; $display("FAIL values_181 got=%0d exp=65522", qa[base+3]); end
            checks++; if (qa[base+5] !== 32'h7FFF_FFFF) begin failures++; $display("FAIL values_saturate got=%0h exp=7fffffff", qa[base+5]); end
            checks++; if (qa[base+6] !== 32'h4000_0000) begin failures++; $display("FAIL values_min_real got=%0h exp=40000000", qa[base+6]); end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [31:0] exp_q[$];
        apply_reset();
        base = qa.size();
        for (int f = 0; f < 2; f++) begin
            randomize_frame(16);
            for (int k = 0; k < 9; k++) exp_q.push_back(pw(fr_re[k], fr_im[k]));
            send_frame(16, 0);
        end
        wait_q(0, base + 18, 150);
        repeat (10) @(negedge clk);
        checks++; if (qa.size() - base !== 18) begin failures++; $display("FAIL b2b_count got=%0d exp=18", qa.size() - base); end
        if (qa.size() - base >= 18) begin
            for (int i = 0; i < 18; i++) begin
                checks++; if (qa[base+i] !== exp_q[i]) begin failures++; $display("FAIL b2b_val[%0d] got=%0h exp=%0h", i, qa[base+i], exp_q[i]); end
            end
            checks++; if (ca[base+9] - ca[base+8] < 1 || ca[base+9] - ca[base+8] > 2) begin failures++; $display("FAIL b2b_frame_gap got=%0d exp=1..2", ca[base+9] - ca[base+8]); end
        end
        checks++; if (ov_a !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", ov_a); end
    endtask

    task automatic test_overrun();
        int base;
        logic [31:0] exp_q[$];
        apply_reset();
        base = qb.size();
        for (int f = 0; f < 3; f++) begin
            randomize_frame(16);
            if (f < 2) for (int k = 0; k < 9; k++) exp_q.push_back(pw(fr_re[k], fr_im[k]));
            send_frame(16, 0);
            if (f == 1) begin
                checks++; if (ov_b !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b exp=0", ov_b); end
            end
        end
        wait_q(1, base + 18, 300);
        repeat (40) @(negedge clk);
        checks++; if (qb.size() - base !== 18) begin failures++; $display("FAIL ovr_count got=%0d exp=18", qb.size() - base); end
        if (qb.size() - base >= 18) begin
            for (int i = 0; i < 18; i++) begin
                checks++; if (qb[base+i] !== exp_q[i]) begin failures++; $display("FAIL ovr_val[%0d] got=%0h exp=%0h", i, qb[base+i], exp_q[i]); end
            end
        end
        checks++; if (ov_b !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", ov_b); end
        repeat (50) @(negedge clk);
        checks++; if (ov_b !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", ov_b); end
        checks++; if (bz_b !== 1'b0) begin failures++; $display("FAIL ovr_busy got=%b exp=0", bz_b); end
    endtask

    task automatic test_gaps();
        int base;
        logic [31:0] exp_q[$];
        apply_reset();
        base = qc.size();
        for (int f = 0; f < 2; f++) begin
            randomize_frame(16);
            for (int k = 0; k < 9; k++) exp_q.push_back(pw(fr_re[k], fr_im[k]));
            send_frame(16, 3);
        end
        wait_q(2, base + 18, 200);
        repeat (20) @(negedge clk);
        checks++; if (qc.size() - base !== 18) begin failures++; $display("FAIL gaps_count got=%0d exp=18", qc.size() - base); end
        if (qc.size() - base >= 18) begin
            for (int i = 0; i < 18; i++) begin
                checks++; if (qc[base+i] !== exp_q[i]) begin failures++; $display("FAIL gaps_val[%0d] got=%0h exp=%0h", i, qc[base+i], exp_q[i]); end
                if (i % 9 != 0) begin
                    checks++; if (cc[base+i] - cc[base+i-1] !== 1) begin failures++; $display("FAIL gaps_spacing[%0d] got=%0d exp=1", i, cc[base+i] - cc[base+i-1]); end
                end
            end
        end
        checks++; if (ov_c !== 1'b0) begin failures++; $display("FAIL gaps_overrun got=%b exp=0", ov_c); end
        checks++; if (fall_c !== last_fd_c + 1) begin failures++; $display("FAIL gaps_busy_fall got=%0d exp=%0d", fall_c, last_fd_c + 1); end
    endtask

    task automatic test_async_reset();
        int base;
        logic [31:0] exp_q[$];
        apply_reset();
        base = qa.size();
        randomize_frame(16);
        send_frame(16, 0);
        wait_q(0, base + 4, 60);
        checks++; if (qa.size() - base < 4) begin failures++; $display("FAIL arst_pre_pulses got=%0d exp=4", qa.size() - base); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (do_a !== 32'sd0) begin failures++; $display("FAIL arst_data_out got=%0h exp=0", do_a); end
        checks++; if ({dv_a, fd_a, bz_a, ov_a} !== 4'b0) begin failures++; $display("FAIL arst_flags got=%b exp=0000", {dv_a, fd_a, bz_a, ov_a}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = qa.size();
        randomize_frame(16);
        for (int k = 0; k < 9; k++) exp_q.push_back(pw(fr_re[k], fr_im[k]));
        send_frame(16, 0);
        wait_q(0, base + 9, 100);
        repeat (10) @(negedge clk);
        checks++; if (qa.size() - base !== 9) begin failures++; $display("FAIL arst_count got=%0d exp=9", qa.size() - base); end
        if (qa.size() - base >= 9) begin
            for (int i = 0; i < 9; i++) begin
                checks++; if (qa[base+i] !== exp_q[i]) begin failures++; $display("FAIL arst_val[%0d] got=%0h exp=%0h", i, qa[base+i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_default();
        int base;
        apply_reset();
        base = qd.size();
        for (int k = 0; k < 512; k++) begin
            fr_re[k] = 16'(k << 8);
            fr_im[k] = 16'sd0;
        end
        send_frame(512, 0);
        wait_q(3, base + 257, 1200);
        repeat (10) @(negedge clk);
        checks++; if (qd.size() - base !== 257) begin failures++; $display("FAIL dflt_count got=%0d exp=257", qd.size() - base); end
        if (qd.size() - base >= 257) begin
            for (int i = 0; i < 257; i++) begin
                checks++; if (qd[base+i] !== pw(fr_re[i], fr_im[i])) begin failures++; $display("FAIL dflt_val[%0d] got=%0h exp=%0h", i, qd[base+i], pw(fr_re[i], fr_im[i])); end
            end
        end
        checks++; if (ov_d !== 1'b0) begin failures++; $display("FAIL dflt_overrun got=%b exp=0", ov_d); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_values();
        test_back_to_back();
        test_overrun();
        test_gaps();
        test_async_reset();
        test_default();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
